// File: rtl/clock_measurement_mc_if.sv
// clock_measurement_mc_if: measurement control, channel inputs and snapshot readback bus
interface clock_measurement_mc_if #(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 24,
  parameter int GEN_WIDTH  = 4,
  parameter int GATE_WIDTH = 24,
  parameter int SEL_WIDTH  = CHANNELS > 1 ? $clog2(CHANNELS) : 1
);
  logic                            en_i;
  logic [GATE_WIDTH-1:0]           gate_len_i;
  logic [CHANNELS-1:0]             ch_pulse_i;
  logic [SEL_WIDTH-1:0]            ch_sel_i;
  logic [GEN_WIDTH+CNT_WIDTH:0]    rd_data_o;
  logic                            done_o;
  logic [CHANNELS-1:0]             stall_o;
  modport master (output en_i, gate_len_i, ch_pulse_i, ch_sel_i, input rd_data_o, done_o, stall_o);
  modport slave (input en_i, gate_len_i, ch_pulse_i, ch_sel_i, output rd_data_o, done_o, stall_o);
endinterface

// File: rtl/clock_measurement_mc.sv
// clock_measurement_mc: multi-channel gated edge counter with per-window snapshots and registered readback.
// Optional zero-edge stall flags are built when CLOCK_MEAS_MC_STALL_EN is defined.
module clock_measurement_mc #(
  parameter int CHANNELS     = 4,
  parameter int CNT_WIDTH    = 24,
  parameter int GEN_WIDTH    = 4,
  parameter int GATE_WIDTH   = 24,
  parameter int SYNC_STAGES  = 2,
  parameter int POSEDGE_ONLY = 0
) (
  input logic clk_i,
  input logic rst_ni,
  clock_measurement_mc_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [CHANNELS-1:0] sync [SYNC_STAGES];
  logic [CHANNELS-1:0] prev, edge_hit, ovf, ovf_nxt, snap_ovf, snap_ovf_nxt;
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_nxt [CHANNELS];
  logic [CNT_WIDTH-1:0] snap [CHANNELS];
  logic [CNT_WIDTH-1:0] snap_nxt [CHANNELS];
  logic [GATE_WIDTH-1:0] len, timer;
  logic [GEN_WIDTH-1:0] gen, gen_nxt;
  logic [GEN_WIDTH+CNT_WIDTH:0] rd_data;
  logic start, run, win_end, done, sel_ok;
  assign edge_hit = (sync[SYNC_STAGES-1] ^ prev) & ((POSEDGE_ONLY != 0) ? ~prev : '1);
  assign sel_ok = int'(bus.ch_sel_i) < CHANNELS;
  always_comb begin
    state_nxt = bus.en_i ? RUN : IDLE;
    start = bus.en_i && state == IDLE;
    run = bus.en_i && state == RUN;
    win_end = run && timer == len - GATE_WIDTH'(1);
  end
  // snapshot views for the commit edge, so readback shows the new window immediately
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt[i] + CNT_WIDTH'(edge_hit[i] && cnt[i] != '1);
      ovf_nxt[i] = ovf[i] | (edge_hit[i] && cnt[i] == '1);
      snap_nxt[i] = win_end ? cnt_nxt[i] : snap[i];
      snap_ovf_nxt[i] = win_end ? ovf_nxt[i] : snap_ovf[i];
    end
    gen_nxt = gen + GEN_WIDTH'(win_end);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
      prev <= '0;
      len <= '0;
      timer <= '0;
      ovf <= '0;
      snap_ovf <= '0;
      gen <= '0;
      done <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      sync[0] <= bus.ch_pulse_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      prev <= sync[SYNC_STAGES-1];
      if (start || win_end) len <= bus.gate_len_i == '0 ? GATE_WIDTH'(1) : bus.gate_len_i;
      timer <= (run && !win_end) ? timer + GATE_WIDTH'(1) : '0;
      ovf <= (run && !win_end) ? ovf_nxt : '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= (run && !win_end) ? cnt_nxt[i] : '0;
        snap[i] <= snap_nxt[i];
      end
      snap_ovf <= snap_ovf_nxt;
      gen <= gen_nxt;
      done <= win_end;
      rd_data <= sel_ok ? {gen_nxt, snap_ovf_nxt[bus.ch_sel_i], snap_nxt[bus.ch_sel_i]} : '0;
    end
  end
  assign bus.rd_data_o = rd_data;
  assign bus.done_o = done;
`ifdef CLOCK_MEAS_MC_STALL_EN
  logic [CHANNELS-1:0] stall;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall <= '0;
    else if (win_end) for (int i = 0; i < CHANNELS; i++) stall[i] <= snap_nxt[i] == '0;
  end
  assign bus.stall_o = stall;
`else
  assign bus.stall_o = '0;
`endif
endmodule

// File: tb/tb_clock_measurement_mc.sv
// tb_clock_measurement_mc: scoreboard bench over a default, a rising-edge-only and a 4-bit-counter instance
`timescale 1ns/1ps
module tb_clock_measurement_mc;
  typedef struct packed {
    logic [3:0] gen;
    logic [15:0] len;
    logic chk_cnt;
    logic [3:0][23:0] c;
    logic [3:0][23:0] p;
    logic [3:0][4:0] s;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, en;
  logic [23:0] gate_len;
  logic [3:0] ch = '0;
  logic [1:0] ch_sel;
  int pat = 3, pc = 0, cyc = 0, ref_cyc = 0, vectors = 0, miscompares = 0;
  exp_t sbq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  clock_measurement_mc_if bus_m ();
  clock_measurement_mc_if bus_p ();
  clock_measurement_mc_if #(.CNT_WIDTH(4)) bus_s ();
  assign bus_m.en_i = en;
  assign bus_m.gate_len_i = gate_len;
  assign bus_m.ch_pulse_i = ch;
  assign bus_m.ch_sel_i = ch_sel;
  assign bus_p.en_i = en;
  assign bus_p.gate_len_i = gate_len;
  assign bus_p.ch_pulse_i = ch;
  assign bus_p.ch_sel_i = ch_sel;
  assign bus_s.en_i = en;
  assign bus_s.gate_len_i = gate_len;
  assign bus_s.ch_pulse_i = ch;
  assign bus_s.ch_sel_i = ch_sel;
  clock_measurement_mc dut_m (.clk_i(clk), .rst_ni(rst_n), .bus(bus_m));
  clock_measurement_mc #(.POSEDGE_ONLY(1)) dut_p (.clk_i(clk), .rst_ni(rst_n), .bus(bus_p));
  clock_measurement_mc #(.CNT_WIDTH(4)) dut_s (.clk_i(clk), .rst_ni(rst_n), .bus(bus_s));
  // pattern 0: ch0 every 5, ch1 every 10, ch3 every 2 cycles; pattern 1: ch0 every cycle; else static
  initial forever begin
    @(negedge clk);
    pc++;
    if (pat == 0) begin
      if (pc % 5 == 0) ch[0] = ~ch[0];
      if (pc % 10 == 0) ch[1] = ~ch[1];
      if (pc % 2 == 0) ch[3] = ~ch[3];
    end else if (pat == 1) ch[0] = ~ch[0];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  function automatic exp_t mk(input int gen, input int len, input bit chk_cnt, input int p);
    exp_t e;
    e = '0;
    e.gen = 4'(gen);
    e.len = 16'(len);
    e.chk_cnt = chk_cnt;
    if (p == 0) begin
      e.c = {24'(len / 2), 24'd0, 24'(len / 10), 24'(len / 5)};
      e.p = {24'(len / 4), 24'd0, 24'(len / 20), 24'(len / 10)};
      e.s = {5'h1f, 5'h00, 5'h1f, 5'h1f};
    end else if (p == 1) begin
      e.c = {24'd0, 24'd0, 24'd0, 24'(len)};
      e.p = {24'd0, 24'd0, 24'd0, 24'(len / 2)};
      e.s = {5'h00, 5'h00, 5'h00, 5'h1f};
    end
    return e;
  endfunction
  task automatic start_en();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 ref_cyc = cyc;
  endtask
  task automatic check_window();
    exp_t e;
    int waited;
    logic [3:0] st;
    e = sbq.pop_front();
    waited = 0;
    do begin
      @(posedge clk);
      #1 waited++;
    end while (!bus_m.done_o && waited < 2000);
    chk("done", 64'(bus_m.done_o), 64'd1);
    chk("interval", 64'(cyc - ref_cyc), 64'(e.len));
    ref_cyc = cyc;
    chk("done_p", 64'(bus_p.done_o), 64'd1);
    chk("done_s", 64'(bus_s.done_o), 64'd1);
    if (!e.chk_cnt) chk("gen", 64'(bus_m.rd_data_o[28:25]), 64'(e.gen));
    else begin
      chk("rd_at_done", 64'(bus_m.rd_data_o), 64'({e.gen, 1'b0, e.c[ch_sel]}));
      for (int i = 0; i < 4; i++) st[i] = e.c[i] == '0;
`ifndef CLOCK_MEAS_MC_STALL_EN
      st = '0;
`endif
      chk("stall", 64'(bus_m.stall_o), 64'(st));
      for (int i = 0; i < 4; i++) begin
        ch_sel = 2'(i);
        @(posedge clk);
        #1 chk("rd", 64'(bus_m.rd_data_o), 64'({e.gen, 1'b0, e.c[i]}));
        chk("rd_p", 64'(bus_p.rd_data_o), 64'({e.gen, 1'b0, e.p[i]}));
        chk("rd_s", 64'(bus_s.rd_data_o), 64'({e.gen, e.s[i]}));
        if (i == 0) chk("done_low", 64'(bus_m.done_o), 64'd0);
      end
    end
  endtask
  initial begin
    int nd;
    rst_n = 1'b1;
    en = 1'b0;
    gate_len = 24'd1000;
    ch_sel = 2'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_rd", 64'(bus_m.rd_data_o), 64'd0);
    chk("rst_done", 64'(bus_m.done_o), 64'd0);
    chk("rst_stall", 64'(bus_m.stall_o), 64'd0);
    chk("rst_rd_p", 64'(bus_p.rd_data_o), 64'd0);
    chk("rst_rd_s", 64'(bus_s.rd_data_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    pat = 0;
    @(posedge clk);
    #1 ref_cyc = cyc;
    sbq.push_back(mk(1, 1000, 0, 0)); check_window();
    sbq.push_back(mk(2, 1000, 1, 0)); check_window();
    gate_len = 24'd500;
    sbq.push_back(mk(3, 1000, 1, 0)); check_window();
    sbq.push_back(mk(4, 500, 1, 0)); check_window();
    pat = 1;
    gate_len = 24'd100;
    sbq.push_back(mk(5, 500, 0, 1)); check_window();
    sbq.push_back(mk(6, 100, 1, 1)); check_window();
    pat = 2;
    sbq.push_back(mk(7, 100, 0, 2)); check_window();
    sbq.push_back(mk(8, 100, 1, 2)); check_window();
    // drop enable mid-window: window discarded, snapshots held
    @(negedge clk);
    en = 1'b0;
    pat = 0;
    gate_len = 24'd1000;
    repeat (20) @(posedge clk);
    start_en();
    nd = 0;
    repeat (600) begin
      @(posedge clk);
      #1 nd += int'(bus_m.done_o);
    end
    @(negedge clk);
    en = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1 nd += int'(bus_m.done_o);
    end
    chk("no_done", 64'(nd), 64'd0);
    chk("hold_rd", 64'(bus_m.rd_data_o), 64'({4'd8, 1'b0, 24'd0}));
    chk("hold_rd_s", 64'(bus_s.rd_data_o), 64'({4'd8, 5'd0}));
    sbq.push_back(mk(9, 1000, 1, 0));
    start_en();
    check_window();
    // zero gate length: one-cycle windows back to back
    @(negedge clk);
    en = 1'b0;
    gate_len = 24'd0;
    start_en();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 chk("l1_done", 64'(bus_m.done_o), 64'd1);
      chk("l1_gen", 64'(bus_m.rd_data_o[28:25]), 64'(10 + k));
    end
    // asynchronous reset mid-window
    @(negedge clk);
    en = 1'b0;
    gate_len = 24'd1000;
    start_en();
    repeat (300) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("mid_rst_rd", 64'(bus_m.rd_data_o), 64'd0);
    chk("mid_rst_done", 64'(bus_m.done_o), 64'd0);
    chk("mid_rst_stall", 64'(bus_m.stall_o), 64'd0);
    chk("mid_rst_rd_p", 64'(bus_p.rd_data_o), 64'd0);
    chk("mid_rst_rd_s", 64'(bus_s.rd_data_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 ref_cyc = cyc;
    sbq.push_back(mk(1, 1000, 0, 0));
    check_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clock_measurement_mc.md
# clock_measurement_mc

Multi-channel gated frequency counter for the board-monitoring block. Each of CHANNELS asynchronous toggle/pulse inputs is synchronised into the `clk_i` domain. Edges are counted over a shared, programmable gate window of `clk_i` cycles, and the per-channel results are snapshotted at the end of every window. Snapshots are read back through a registered channel-select mux with a generation tag, so software can compute all channel frequencies against one reference clock.

## Interface
Parameters:
- CHANNELS, 4 — number of measured inputs (1..16)
- CNT_WIDTH, 24 — edge counter / result width
- GEN_WIDTH, 4 — window generation counter width
- GATE_WIDTH, 24 — gate length width
- SYNC_STAGES, 2 — synchroniser depth per channel (>=2)
- POSEDGE_ONLY, 0 — 1: count rising edges only; 0: count both edges

Ports:
- clk_i  in  1  — reference/measurement clock; the single clock of the block
- rst_ni  in  1  — reset, asynchronous, active-low
- en_i  in  1  — measurement enable
- gate_len_i  in  GATE_WIDTH  — window length in `clk_i` cycles
- ch_pulse_i  in  CHANNELS  — asynchronous channel inputs
- ch_sel_i  in  max(1,$clog2(CHANNELS))  — readback channel select
- rd_data_o  out  GEN_WIDTH+1+CNT_WIDTH  — {generation, overflow, count} of the selected channel
- done_o  out  1  — one-cycle pulse when a new snapshot is committed
- stall_o  out  CHANNELS  — per-channel zero-edge flag (see Configuration)

## Operation
- Per channel: SYNC_STAGES flops (reset 0), then a previous-value register. An edge is `sync != prev`, qualified by `prev == 0` when POSEDGE_ONLY=1.
- Gate timer: when `en_i` rises (or after reset with `en_i` high), the block latches `gate_len_i` as L and starts the timer at 0. A latched value of 0 is treated as 1.
- Window: cycles 0..L-1. The edge counters count every qualified edge in those cycles, including the last cycle.
- Counters saturate at all-ones. Any increment attempted at saturation sets the channel's sticky window-overflow bit.
- End of window (timer == L-1), all channels in the same cycle:
  - snapshot ← counter (+1 if an edge occurs this cycle, saturating)
  - snapshot overflow ← overflow bit
  - counters and overflow bits clear
  - generation increments (wraps modulo 2^GEN_WIDTH)
  - `gate_len_i` is re-latched as the next L
  - the timer restarts at 0; there are no dead cycles between windows
- `gate_len_i` changes mid-window take effect only at the next window start.
- `en_i` low: the timer, counters and overflow bits are held at 0. The synchronisers keep running. Snapshots, generation, `rd_data_o` and `stall_o` retain their values.
- `en_i` deasserted mid-window: the window is discarded. There is no snapshot and no `done_o`.
- `rd_data_o` is a registered mux of {generation, snapshot overflow, snapshot[ch_sel_i]}. An out-of-range `ch_sel_i` returns all zeros.

## Timing
- Reset values: `rd_data_o` = 0, `done_o` = 0, `stall_o` = 0, generation = 0, all snapshots = 0.
- Input-to-count latency: an edge on `ch_pulse_i` is counted SYNC_STAGES+1 cycles after it is captured by the first flop.
  - Edges in the last SYNC_STAGES+1 cycles before a window end land in the next window.
- `done_o` is high for exactly one cycle, in the cycle after the window-end cycle.
- `rd_data_o` reflects the new snapshot in that same cycle, for the `ch_sel_i` value present in the window-end cycle.
- `ch_sel_i` change to `rd_data_o` update: 1 cycle.
- Asynchronous reset mid-window: all state clears immediately. If `en_i` is high, counting resumes with a fresh window at generation 0 on the first clock after release.

## Configuration
- CLOCK_MEAS_MC_STALL_EN defined:
  - at each snapshot, `stall_o[i]` ← (snapshot count == 0)
  - the flag is updated every window and cleared by the next nonzero snapshot
  - `stall_o` changes in the same cycle as `done_o`
- Not defined: `stall_o` is tied to 0 and no per-channel comparison logic is built.

## Test plan
- CHANNELS=4, L=1000, ch0 toggling every 5 cycles, ch1 every 10, ch2 static, ch3 every 2 cycles, POSEDGE_ONLY=0
  -> steady-state snapshots of 200 (±1), 100 (±1), 0 and 500 (±1).
  -> `done_o` pulses every 1000 cycles, generation increments, and `stall_o` = 4'b0100 when the macro is defined.
- POSEDGE_ONLY=1, same stimulus -> snapshots 100 (±1), 50 (±1), 0 and 250 (±1).
- CNT_WIDTH=4, L=100, ch0 toggling every cycle -> ch0 snapshot 15 with overflow=1. The next window with a static input gives count 0 with overflow=0.
- `gate_len_i` changed from 1000 to 500 mid-window -> the current window ends at 1000 cycles and the following window at 500. `gate_len_i`=0 -> a snapshot every cycle.
- `en_i` dropped at cycle 600 of a 1000-cycle window, then reasserted -> no `done_o` and snapshots unchanged. The first new `done_o` arrives 1000 cycles after reassertion.
- `rst_ni` pulsed low mid-window -> all outputs 0 immediately. After release, generation reads 1 at the first `done_o`.
